// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK_WID-bit CLA slice per stage, valid/ready backpressure.
// Optional PIPELINED_CLA_SAT_EN clamps overflowing results to signed max/min.
module pipelined_cla_adder #(
    parameter int DATA_WID  = 32,
    parameter int BLOCK_WID = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_WID-1:0] in1,
    input  logic [DATA_WID-1:0] in2,
    input  logic                carry_in,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_WID-1:0] sum,
    output logic                carry_out,
    output logic                overflow,
    output logic                zero
);

    localparam int NUM_STAGES = DATA_WID / BLOCK_WID;

    if ((BLOCK_WID < 1) || ((DATA_WID % BLOCK_WID) != 0)) begin : g_width_check
        $error("pipelined_cla_adder: DATA_WID must be a multiple of BLOCK_WID");
    end

    logic advance;

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic [DATA_WID-1:0]  a_in;
        logic [DATA_WID-1:0]  b_in;
        logic [DATA_WID-1:0]  s_in;
        logic                 c_in;
        logic                 v_in;
        logic [BLOCK_WID-1:0] g;
        logic [BLOCK_WID-1:0] p;
        logic [BLOCK_WID-1:0] slice_sum;
        logic [BLOCK_WID:0]   c;
        logic [DATA_WID-1:0]  s_nxt;

        if (k == 0) begin : g_first
            assign a_in = in1;
            assign b_in = sub ? ~in2 : in2;
            assign c_in = sub | carry_in;
            assign s_in = '0;
            assign v_in = in_valid;
        end else begin : g_chain
            assign a_in = g_stage[k-1].g_mid.a_q;
            assign b_in = g_stage[k-1].g_mid.b_q;
            assign s_in = g_stage[k-1].g_mid.s_q;
            assign c_in = g_stage[k-1].g_mid.c_q;
            assign v_in = g_stage[k-1].g_mid.v_q;
        end

        // Operands are shifted down each stage, so the active slice is always the low BLOCK_WID bits.
        always_comb begin
            g    = a_in[BLOCK_WID-1:0] & b_in[BLOCK_WID-1:0];
            p    = a_in[BLOCK_WID-1:0] | b_in[BLOCK_WID-1:0];
            c    = '0;
            c[0] = c_in;
            for (int unsigned i = 0; i < BLOCK_WID; i++) begin
                c[i+1] = g[i] | (p[i] & c[i]);
            end
            slice_sum = a_in[BLOCK_WID-1:0] ^ b_in[BLOCK_WID-1:0] ^ c[BLOCK_WID-1:0];
        end

        // Resolved slices enter the skew register from the top and drift down into place.
        assign s_nxt = (s_in >> BLOCK_WID) | (DATA_WID'(slice_sum) << (DATA_WID - BLOCK_WID));

        if (k < NUM_STAGES - 1) begin : g_mid
            logic [DATA_WID-1:0] a_q;
            logic [DATA_WID-1:0] b_q;
            logic [DATA_WID-1:0] s_q;
            logic                c_q;
            logic                v_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                end else if (advance) begin
                    v_q <= v_in;
                    c_q <= c[BLOCK_WID];
                    a_q <= a_in >> BLOCK_WID;
                    b_q <= b_in >> BLOCK_WID;
                    s_q <= s_nxt;
                end
            end
        end else begin : g_last
            logic                ovf;
            logic [DATA_WID-1:0] res;

            assign ovf = c[BLOCK_WID-1] ^ c[BLOCK_WID];
`ifdef PIPELINED_CLA_SAT_EN
            // a_in[BLOCK_WID-1] is in1's MSB once all lower slices have been shifted out.
            assign res = ovf ? {a_in[BLOCK_WID-1], {(DATA_WID-1){~a_in[BLOCK_WID-1]}}} : s_nxt;
`else
            assign res = s_nxt;
`endif

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    sum       <= '0;
                    carry_out <= 1'b0;
                    overflow  <= 1'b0;
                    zero      <= 1'b0;
                end else if (advance) begin
                    out_valid <= v_in;
                    if (v_in) begin
                        sum       <= res;
                        carry_out <= c[BLOCK_WID];
                        overflow  <= ovf;
                        zero      <= ~|res;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder (DATA_WID=32, BLOCK_WID=8, latency 4).
// Directed vectors; expected results are pushed on acceptance and popped by an output monitor.
module tb_pipelined_cla_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        carry_in;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        carry_out;
    logic        overflow;
    logic        zero;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

`ifdef PIPELINED_CLA_SAT_EN
    localparam logic [31:0] SUB_OVF_SUM = 32'h8000_0000;
    localparam logic [31:0] ADD_OVF_SUM = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] SUB_OVF_SUM = 32'h7FFF_FFFF;
    localparam logic [31:0] ADD_OVF_SUM = 32'h8000_0000;
`endif

    pipelined_cla_adder #(
        .DATA_WID (32),
        .BLOCK_WID(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in1      (in1),
        .in2      (in2),
        .carry_in (carry_in),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .carry_out(carry_out),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb,
                        input logic [31:0] es, input logic ec, input logic eo, input logic ez);
        bit ok = 0;
        in1      = a;
        in2      = b;
        carry_in = ci;
        sub      = sb;
        in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (ok) exp_q.push_back('{s: es, c: ec, o: eo, z: ez});
        else    chk("accept_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic lat_check(input string name);
        int lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk(name, lat, 4);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge clk);
        chk("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sum", sum, mon_e.s);
                chk("carry_out", carry_out, mon_e.c);
                chk("overflow", overflow, mon_e.o);
                chk("zero", zero, mon_e.z);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in1       = '0;
        in2       = '0;
        carry_in  = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_carry_out", carry_out, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_zero", zero, 0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Cross-slice carry and latency
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        lat_check("latency_first");
        drain();

        // Back-to-back directed vectors
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, SUB_OVF_SUM,   1'b1, 1'b1, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, ADD_OVF_SUM,   1'b0, 1'b1, 1'b0);
        send(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0, 32'h2222_2221, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        send(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        drain();

        // Backpressure: 3-cycle stall while the first result is presented
        fork
            begin
                for (int i = 1; i <= 6; i++)
                    send(32'(i), 32'(10 * i), 1'b0, 1'b0, 32'(11 * i), 1'b0, 1'b0, 1'b0);
            end
            begin
                int n = 0;
                while (!out_valid && n < 20) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_sum", sum, 11);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight
        send(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0002, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0003, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0006, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("midrst_out_valid", out_valid, 0);
        rst = 1'b0;
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0, 32'h0000_000C, 1'b0, 1'b0, 1'b0);
        lat_check("latency_after_reset");
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined successor to the team's combinational carry-lookahead adder.
- Splits the DATA_WID addition into BLOCK_WID-bit carry-lookahead slices, one slice per pipeline stage, with the inter-slice carry registered.
- Supports add/subtract mode, a valid/ready handshake with backpressure, and carry/overflow/zero flags.
- Sits in the datapath wherever full-width single-cycle carry chains miss timing.

Parameters:
- DATA_WID, 32, operand and result width in bits.
- BLOCK_WID, 8, bits resolved per stage. DATA_WID must be a multiple of BLOCK_WID; elaboration fails otherwise.
- NUM_STAGES, DATA_WID/BLOCK_WID, derived (localparam), pipeline depth and latency in cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in1  in  DATA_WID  operand A.
- in2  in  DATA_WID  operand B.
- carry_in  in  1  carry into bit 0 (add mode only).
- sub  in  1  0 = A+B+carry_in; 1 = A-B.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  DATA_WID  result.
- carry_out  out  1  carry out of the MSB (sub mode: 1 = no borrow).
- overflow  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: every stage valid bit, out_valid, sum, carry_out, overflow and zero clear to 0 on the first clk edge with rst=1. in_ready=1 while rst=0 and the pipe is empty.
- Reset mid-operation: all in-flight beats are discarded, with no partial output.
- Operand prep in stage 0: B' = sub ? ~in2 : in2; c0 = sub ? 1 : carry_in.
- Stage k (0..NUM_STAGES-1):
  - Computes bits [k*BLOCK_WID +: BLOCK_WID] with generate g=a&b, propagate p=a|b, lookahead carries and sum bit = a^b^c.
  - Registers the slice result, the slice carry-out and the remaining unprocessed operand bits.
  - Already-resolved lower sum bits ride along in a skew register.
- Output: the final stage drives sum, carry_out = carry from bit DATA_WID-1, overflow = carry into MSB XOR carry out of MSB, and zero = ~|sum. All outputs are registered.
- Handshake:
  - advance = out_ready | ~out_valid.
  - in_ready = advance.
  - A beat is accepted when in_valid & in_ready.
  - When advance=0 the whole pipe stalls: every stage holds, and sum and the flags stay stable while out_valid=1.
  - When advance=1 every stage shifts by one, and empty stages carry bubbles (valid=0).
- Latency: NUM_STAGES cycles from acceptance to out_valid while out_ready=1. Throughput is 1 beat/cycle.
- Simultaneous accept and output: permitted in the same cycle with no bubble inserted.
- Bubbles are not collapsed. A stalled pipe with gaps keeps its gaps.
- Outputs while out_valid=0 hold their last value and must not be interpreted.
- Width rule: sum is exactly DATA_WID bits and wraps modulo 2^DATA_WID, except as modified by SAT_EN.
- NUM_STAGES=1 degenerates to a registered single-stage CLA with latency 1.

Optional Feature:
- Macro: PIPELINED_CLA_SAT_EN.
- Defined:
  - When overflow=1 in the final stage, sum is clamped to signed max (0x7FFF_FFFF for 32 bits) if in1's MSB=0, else signed min (0x8000_0000).
  - overflow still reports 1; zero is computed on the clamped value; carry_out is unchanged.
- Undefined: sum wraps, and no clamp logic is synthesised.

Test Plan:
- Reset then idle: after 2 cycles of rst=1 -> out_valid=0, sum=0, in_ready=1.
- Add, DATA_WID=32, BLOCK_WID=8: in1=0x0000_00FF, in2=0x0000_0001, carry_in=0, out_ready=1 -> after 4 cycles sum=0x0000_0100, carry_out=0, overflow=0, zero=0. This checks the cross-slice carry.
- Full ripple: in1=0xFFFF_FFFF, in2=0, carry_in=1 -> sum=0, carry_out=1, zero=1, overflow=0.
- Subtract with overflow: sub=1, in1=0x8000_0000, in2=1 -> sum=0x7FFF_FFFF, overflow=1, carry_out=1. With PIPELINED_CLA_SAT_EN defined -> sum=0x8000_0000.
- Backpressure: stream 6 beats back-to-back (A=i, B=10*i), drop out_ready for 3 cycles mid-stream -> in_ready=0 during the stall, sum held stable, all 6 results (11*i) delivered in order with no loss or duplication.
- Reset mid-stream: 3 beats in flight, assert rst for 1 cycle -> out_valid=0 on the next cycle. A subsequent beat 5+7 emerges as 12 after exactly 4 cycles.
